store_rmw_unit: RTL and testbench

- Store-side data narrowing unit in the MEM stage. It is the write-direction counterpart of immediate/load extension: it packs a 32-bit register value down to a byte or halfword lane.
- The data memory is word-only, so SB/SH become a read-modify-write sequence; SW is a single write.
- Misaligned stores raise an address-store exception to the interrupt/CP0 logic.
- Stalls the pipeline while busy.

---
 rtl/store_rmw_unit_pkg.sv | 35 +++
 rtl/store_lane_merge.sv | 45 ++++
 rtl/store_rmw_unit.sv | 155 +++++++++++++++
 tb/tb_store_rmw_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_rmw_unit_pkg.sv
// Shared definitions for the store read-modify-write unit.
//   - store size encodings (word / half / byte, 2'b11 behaves as word)
//   - controller state encoding
//   - alignment and RMW classification helpers
// Used by store_rmw_unit and store_lane_merge.
package store_rmw_unit_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_READ    = 2'b01,
        ST_RD_WAIT = 2'b10,
        ST_WRITE   = 2'b11
    } state_t;

    // Bytes are always aligned; halves need addr[0]=0; words (and the
    // reserved 2'b11 size) need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            default:   return addr_lo != 2'b00;
        endcase
    endfunction

    // Sub-word stores need the old word because memory is word-only.
    function automatic logic needs_rmw(input logic [1:0] size);
        return (size == SIZE_BYTE) || (size == SIZE_HALF);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational store lane packer.
// Ports:
//   old_word - word read back from memory (ignored lanes are kept)
//   wdata    - rt register value
//   addr_lo  - byte address bits [1:0]
//   size     - store size encoding
//   merged   - old_word with the addressed lane(s) replaced
//   lane     - store data replicated across the word
//   be       - byte enables of the addressed lane(s), little-endian
module store_lane_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    output logic [31:0] merged,
    output logic [31:0] lane,
    output logic [3:0]  be
);

    logic [31:0] mask;

    always_comb begin
        lane = wdata;
        be   = 4'b1111;
        case (size)
            SIZE_BYTE: begin
                lane = {4{wdata[7:0]}};
                be   = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                lane = {2{wdata[15:0]}};
                be   = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: begin
                lane = wdata;
                be   = 4'b1111;
            end
        endcase
        mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        merged = (old_word & ~mask) | (lane & mask);
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store-side data narrowing unit for the MEM stage. SW is a single word
// write; SB/SH become read-modify-write on the word-only data memory.
// Misaligned stores pulse exc_ades and record exc_badvaddr.
// Build option: STORE_RMW_BYTE_STROBE_EN adds mem_be and turns every
// store into a single strobed write of the replicated lane.
// Ports:
//   clk, rstn                  - clock, synchronous active-low reset
//   req_valid/ready/addr/wdata/size - store request (ready only in IDLE)
//   busy, req_done             - stall while active, pulse on final write
//   exc_ades, exc_badvaddr     - misaligned-store pulse and faulting address
//   mem_addr/rd_en/rdata/wr_en/wdata (+ mem_be) - word memory interface
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int MEM_RD_LATENCY = 1,
    parameter int ADDR_W         = 32
)(
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              busy,
    output logic              req_done,
    output logic              exc_ades,
    output logic [ADDR_W-1:0] exc_badvaddr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
`ifdef STORE_RMW_BYTE_STROBE_EN
    output logic [3:0]        mem_be,
`endif
    output logic [31:0]       mem_wdata
);

    localparam logic [1:0] LAT_M1 = 2'(MEM_RD_LATENCY - 1);

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       merge_q;
    logic [1:0]        cnt;
    logic              accept, misaligned;
    logic [31:0]       merged_w, lane_w;
    logic [3:0]        be_w;

    assign accept     = req_valid && (state == ST_IDLE);
    assign misaligned = is_misaligned(req_size, req_addr[1:0]);

`ifdef STORE_RMW_BYTE_STROBE_EN
    logic [3:0] be_q;

    // Lane is packed straight from the request; no old word is needed.
    store_lane_merge u_merge (
        .old_word (32'h0),
        .wdata    (req_wdata),
        .addr_lo  (req_addr[1:0]),
        .size     (req_size),
        .merged   (merged_w),
        .lane     (lane_w),
        .be       (be_w)
    );

    logic unused_strobe;
    assign unused_strobe = ^{merged_w, mem_rdata, addr_q[1:0]};
    assign mem_be        = be_q;
`else
    logic [31:0] wdata_q;
    logic [1:0]  size_q;

    store_lane_merge u_merge (
        .old_word (mem_rdata),
        .wdata    (wdata_q),
        .addr_lo  (addr_q[1:0]),
        .size     (size_q),
        .merged   (merged_w),
        .lane     (lane_w),
        .be       (be_w)
    );

    logic unused_rmw;
    assign unused_rmw = ^{lane_w, be_w};
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept && !misaligned) begin
`ifdef STORE_RMW_BYTE_STROBE_EN
                    next_state = ST_WRITE;
`else
                    next_state = needs_rmw(req_size) ? ST_READ : ST_WRITE;
`endif
                end
            end
            ST_READ:    next_state = ST_RD_WAIT;
            ST_RD_WAIT: if (cnt == 2'd0) next_state = ST_WRITE;
            ST_WRITE:   next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            merge_q      <= '0;
            cnt          <= '0;
            exc_ades     <= 1'b0;
            exc_badvaddr <= '0;
`ifdef STORE_RMW_BYTE_STROBE_EN
            be_q         <= '0;
`else
            wdata_q      <= '0;
            size_q       <= SIZE_WORD;
`endif
        end else begin
            state    <= next_state;
            exc_ades <= accept && misaligned;
            if (accept && misaligned) exc_badvaddr <= req_addr;
            if (accept && !misaligned) begin
                addr_q <= req_addr;
`ifdef STORE_RMW_BYTE_STROBE_EN
                merge_q <= lane_w;
                be_q    <= be_w;
`else
                wdata_q <= req_wdata;
                size_q  <= req_size;
                // SW writes the register value as-is; SB/SH overwrite
                // this with the merged word once the read returns.
                merge_q <= req_wdata;
`endif
            end
            if (state == ST_READ)
                cnt <= LAT_M1;
            else if (state == ST_RD_WAIT && cnt != 2'd0)
                cnt <= cnt - 2'd1;
`ifndef STORE_RMW_BYTE_STROBE_EN
            if (state == ST_RD_WAIT && cnt == 2'd0) merge_q <= merged_w;
`endif
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign mem_rd_en = (state == ST_READ);
    assign mem_wr_en = (state == ST_WRITE);
    assign req_done  = (state == ST_WRITE);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = merge_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
module tb_store_rmw_unit;

    localparam int LAT = 3;
`ifdef STORE_RMW_BYTE_STROBE_EN
    localparam bit STROBE = 1'b1;
`else
    localparam bit STROBE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        busy, req_done, exc_ades;
    logic [31:0] exc_badvaddr, mem_addr, mem_rdata, mem_wdata;
    logic        mem_rd_en, mem_wr_en;
    logic [3:0]  be_eff;
`ifdef STORE_RMW_BYTE_STROBE_EN
    logic [3:0]  mem_be;
    assign be_eff = mem_be;
`else
    assign be_eff = 4'hF;
`endif

    always #5 clk = ~clk;

    store_rmw_unit #(.MEM_RD_LATENCY(LAT), .ADDR_W(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .busy         (busy),
        .req_done     (req_done),
        .exc_ades     (exc_ades),
        .exc_badvaddr (exc_badvaddr),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rdata    (mem_rdata),
        .mem_wr_en    (mem_wr_en),
`ifdef STORE_RMW_BYTE_STROBE_EN
        .mem_be       (mem_be),
`endif
        .mem_wdata    (mem_wdata)
    );

    // ---------------- memory model (word array, fixed read latency) -------
    bit [31:0]    mem [256];
    bit [LAT-1:0] rd_pipe;
    bit [7:0]     ad_pipe [LAT];
    bit [31:0]    junk;
    bit           pre_en;
    bit [7:0]     pre_idx;
    bit [31:0]    pre_val;
    logic [31:0]  bmask;

    assign bmask     = {{8{be_eff[3]}}, {8{be_eff[2]}}, {8{be_eff[1]}}, {8{be_eff[0]}}};
    assign mem_rdata = rd_pipe[LAT-1] ? mem[ad_pipe[LAT-1]] : junk;

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            rd_pipe[i] <= rd_pipe[i-1];
            ad_pipe[i] <= ad_pipe[i-1];
        end
        rd_pipe[0] <= mem_rd_en;
        ad_pipe[0] <= mem_addr[9:2];
        junk       <= $urandom;
        if (pre_en)
            mem[pre_idx] <= pre_val;
        else if (mem_wr_en)
            mem[mem_addr[9:2]] <= (mem[mem_addr[9:2]] & ~bmask) | (mem_wdata & bmask);
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [256];

    function automatic bit ref_mis(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b10) return 1'b0;
        if (s == 2'b01) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [31:0] a, input logic [1:0] s);
        int sh;
        if (s == 2'b10) begin
            sh = 8 * int'(a % 4);
            return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end
        if (s == 2'b01) begin
            sh = ((a % 4) >= 2) ? 16 : 0;
            return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    function automatic logic [31:0] ref_lane(input logic [31:0] wd, input logic [1:0] s);
        if (s == 2'b10) return (wd & 32'hFF) * 32'h0101_0101;
        if (s == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b10) return 4'(1 << (a % 4));
        if (s == 2'b01) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
        return 4'hF;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_exc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   rd_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (mem_rd_en) rd_pulses++;
                if (mem_wr_en || exc_ades) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: wr=%0b exc=%0b addr=%h with nothing expected",
                                 mem_wr_en, exc_ades, mem_addr);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("event_kind", 32'(exc_ades), 32'(mon_e.is_exc));
                        if (mem_wr_en) begin
                            chk("wr_addr", mem_addr, mon_e.addr);
                            chk("wr_data", mem_wdata, mon_e.data);
                            chk("wr_done", 32'(req_done), 32'd1);
`ifdef STORE_RMW_BYTE_STROBE_EN
                            chk("wr_be", 32'(mem_be), 32'(mon_e.be));
`endif
                        end else begin
                            chk("badvaddr", exc_badvaddr, mon_e.addr);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        ref_mem[idx] = val;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] s,
                         input bit junk_en);
        bit          mis, seen;
        int          cyc, lat_exp, busy_cnt, rd0;
        logic [31:0] newv;
        exp_t        e;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        mis = ref_mis(a, s);
        if (mis) begin
            e = '{is_exc: 1'b1, addr: a, data: 32'h0, be: 4'h0};
            lat_exp = 1;
        end else begin
            newv = ref_store(ref_mem[a[9:2]], wd, a, s);
            ref_mem[a[9:2]] = newv;
            e = '{is_exc: 1'b0, addr: a & 32'hFFFF_FFFC,
                  data: STROBE ? ref_lane(wd, s) : newv, be: ref_be(a, s)};
            lat_exp = (STROBE || (s != 2'b01 && s != 2'b10)) ? 1 : 2 + LAT;
        end
        exp_q.push_back(e);
        rd0 = rd_pulses;
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = wd;
        req_size  = s;
        @(posedge clk); #1;
        // garbage on the request bus while busy must be ignored
        req_valid = !mis && junk_en;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        cyc = 1;
        seen = 1'b0;
        busy_cnt = 0;
        while (cyc <= 20) begin
            busy_cnt += int'(busy);
            if (mis ? exc_ades : req_done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: addr=%h size=%0d no completion within 20 cycles", a, s);
        end else begin
            chk("latency", 32'(cyc), 32'(lat_exp));
            chk("busy_cycles", 32'(busy_cnt), mis ? 32'd0 : 32'(lat_exp));
            chk("rd_pulses", 32'(rd_pulses - rd0),
                (!mis && !STROBE && (s == 2'b01 || s == 2'b10)) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        // reset held while memory is filled
        for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
        preload(8'h80, 32'h1122_3344);
        preload(8'hC0, 32'h1122_3344);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_ready",    32'(req_ready), 32'd1);
        chk("rst_done",     32'(req_done), 32'd0);
        chk("rst_exc",      32'(exc_ades), 32'd0);
        chk("rst_rd_en",    32'(mem_rd_en), 32'd0);
        chk("rst_wr_en",    32'(mem_wr_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wdata",    mem_wdata, 32'd0);
        chk("rst_badvaddr", exc_badvaddr, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        store(32'h100, 32'hDEAD_BEEF, 2'b00, 1'b0);
        store(32'h203, 32'h0000_00AB, 2'b10, 1'b0);
        store(32'h302, 32'h0000_CAFE, 2'b01, 1'b0);
        store(32'h401, 32'h1234_5678, 2'b01, 1'b0);
        store(32'h502, 32'h0000_005A, 2'b10, 1'b0);
        store(32'h10C, 32'h0BAD_F00D, 2'b11, 1'b1);
        store(32'h10E, 32'h0000_0001, 2'b00, 1'b0);

`ifndef STORE_RMW_BYTE_STROBE_EN
        // reset while the read of an SB is outstanding
        req_valid = 1'b1;
        req_addr  = 32'h208;
        req_wdata = 32'h0000_0077;
        req_size  = 2'b10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("midop_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("midop_rst_busy",  32'(busy), 32'd0);
        chk("midop_rst_wr_en", 32'(mem_wr_en), 32'd0);
        rstn = 1'b1;
        repeat (LAT + 3) begin
            @(posedge clk); #1;
        end
        store(32'h208, 32'hFEED_FACE, 2'b00, 1'b0);
`endif

        for (int n = 0; n < 80; n++) begin
            a = 32'($urandom_range(0, 1023));
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) begin
                if (s == 2'b01) a = a & 32'hFFFF_FFFE;
                else if (s != 2'b10) a = a & 32'hFFFF_FFFC;
            end
            store(a, $urandom, s, 1'($urandom_range(0, 1)));
        end

        repeat (LAT + 4) begin
            @(posedge clk); #1;
        end
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
